// File: rtl/demux_router.sv
// demux_router: routes input beats to one of four output channels through a
// single-entry output register with valid/ready handshakes on both sides.
// Ports: clk, rst (sync, active-high); in_data/in_sel/in_valid/in_last/in_ready
// input side; out_data/out_last/out_valid[3:0]/out_ready[3:0] output side;
// pkt_cnt counts packets whose last beat was accepted.
module demux_router #(
    parameter int WIDTH = 8,
    parameter bit LOCK  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_sel,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [7:0]       pkt_cnt
);

    typedef enum logic {
        IDLE,
        PKT
    } state_t;

    state_t     state;
    logic       full;
    logic [1:0] out_dest;
    logic [1:0] dest_q;
    logic       accept;
    logic       done;
    logic [1:0] dest;

    // The slot frees up in the same cycle its beat drains.
    assign in_ready  = !full || out_ready[out_dest];
    assign accept    = in_valid && in_ready;
    assign done      = full && out_ready[out_dest];
    assign dest      = (state == PKT) ? dest_q : in_sel;
    assign out_valid = full ? (4'b0001 << out_dest) : 4'b0000;

    always_ff @(posedge clk) begin
        if (rst) begin
            full     <= 1'b0;
            out_dest <= 2'd0;
            out_data <= '0;
            out_last <= 1'b0;
        end else if (accept) begin
            full     <= 1'b1;
            out_dest <= dest;
            out_data <= in_data;
            out_last <= in_last;
        end else if (done) begin
            full <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt <= 8'd0;
        end else if (accept && in_last) begin
            pkt_cnt <= pkt_cnt + 8'd1;
        end
    end

    // Destination lock: only multi-beat packets leave IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            dest_q <= 2'd0;
        end else if (LOCK && accept) begin
            unique case (state)
                IDLE: begin
                    if (!in_last) begin
                        state  <= PKT;
                        dest_q <= in_sel;
                    end
                end
                PKT: begin
                    if (in_last) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_demux_router.sv
// tb_demux_router: drives a LOCK=0 and a LOCK=1 router with shared stimulus,
// compares both against a behavioural model every cycle, plus literal checks.
module tb_demux_router;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic [1:0] in_sel;
    logic       in_valid;
    logic       in_last;
    logic [3:0] out_ready;

    logic       r0, r1;
    logic [7:0] d0, d1;
    logic       l0, l1;
    logic [3:0] v0, v1;
    logic [7:0] c0, c1;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    demux_router #(.WIDTH(8), .LOCK(1'b0)) u0 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel),
        .in_valid(in_valid), .in_last(in_last), .in_ready(r0),
        .out_data(d0), .out_last(l0), .out_valid(v0),
        .out_ready(out_ready), .pkt_cnt(c0)
    );

    demux_router #(.WIDTH(8), .LOCK(1'b1)) u1 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel),
        .in_valid(in_valid), .in_last(in_last), .in_ready(r1),
        .out_data(d1), .out_last(l1), .out_valid(v1),
        .out_ready(out_ready), .pkt_cnt(c1)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: a one-slot buffer per instance, plus the
    // destination a packet is pinned to when locking applies.
    typedef struct {
        logic [1:0] dest;
        logic [7:0] data;
        logic       last;
    } beat_t;

    beat_t      slot_q[2][$];
    beat_t      hold[2];
    bit         in_pkt[2];
    logic [1:0] pkt_dest[2];
    int         mcnt[2];

    function automatic bit m_ready(input int k);
        if (slot_q[k].size() == 0) return 1'b1;
        return out_ready[slot_q[k][0].dest];
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                slot_q[k].delete();
                hold[k] = '{dest: 2'd0, data: 8'd0, last: 1'b0};
                in_pkt[k] = 1'b0;
                pkt_dest[k] = 2'd0;
                mcnt[k] = 0;
            end else begin
                bit acc;
                beat_t b;
                acc = in_valid && m_ready(k);
                if (slot_q[k].size() != 0 && out_ready[slot_q[k][0].dest])
                    void'(slot_q[k].pop_front());
                if (acc) begin
                    b.dest = (k == 1 && in_pkt[k]) ? pkt_dest[k] : in_sel;
                    b.data = in_data;
                    b.last = in_last;
                    slot_q[k].push_back(b);
                    hold[k] = b;
                    if (k == 1) begin
                        if (in_pkt[k]) begin
                            if (in_last) in_pkt[k] = 1'b0;
                        end else if (!in_last) begin
                            in_pkt[k] = 1'b1;
                            pkt_dest[k] = in_sel;
                        end
                    end
                    if (in_last) mcnt[k] = (mcnt[k] + 1) % 256;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [3:0] ev;
            for (int k = 0; k < 2; k++) begin
                ev = (slot_q[k].size() != 0) ? (4'b0001 << hold[k].dest) : 4'b0;
                if (k == 0) begin
                    chk("m0_in_ready", 32'(r0), 32'(m_ready(0)));
                    chk("m0_out_valid", 32'(v0), 32'(ev));
                    chk("m0_out_data", 32'(d0), 32'(hold[0].data));
                    chk("m0_out_last", 32'(l0), 32'(hold[0].last));
                    chk("m0_pkt_cnt", 32'(c0), 32'(mcnt[0]));
                end else begin
                    chk("m1_in_ready", 32'(r1), 32'(m_ready(1)));
                    chk("m1_out_valid", 32'(v1), 32'(ev));
                    chk("m1_out_data", 32'(d1), 32'(hold[1].data));
                    chk("m1_out_last", 32'(l1), 32'(hold[1].last));
                    chk("m1_pkt_cnt", 32'(c1), 32'(mcnt[1]));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d,
                         input logic [1:0] s, input logic l);
        in_valid = v;
        in_data  = d;
        in_sel   = s;
        in_last  = l;
    endtask

    initial begin
        rst = 1'b1;
        out_ready = 4'b1111;
        drive(1'b1, 8'h5A, 2'd1, 1'b1);
        step();
        chk_en = 1'b1;
        step();
        rst = 1'b0;
        drive(1'b0, 8'h00, 2'd0, 1'b0);
        @(negedge clk);
        chk("rst_out_valid", 32'(v0), 32'h0);
        chk("rst_pkt_cnt", 32'(c0), 32'h0);
        chk("rst_in_ready", 32'(r0), 32'h1);

        drive(1'b1, 8'hA5, 2'd2, 1'b1);
        step();
        drive(1'b0, 8'h00, 2'd0, 1'b0);
        @(negedge clk);
        chk("single_valid", 32'(v0), 32'h4);
        chk("single_data", 32'(d0), 32'hA5);
        chk("single_last", 32'(l0), 32'h1);
        chk("single_cnt", 32'(c0), 32'h1);
        step();

        out_ready = 4'b0000;
        drive(1'b1, 8'h11, 2'd1, 1'b1);
        step();
        drive(1'b1, 8'h22, 2'd3, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(r0), 32'h0);
            chk("bp_hold_data", 32'(d0), 32'h11);
            chk("bp_hold_valid", 32'(v0), 32'h2);
            step();
        end
        out_ready = 4'b0010;
        @(negedge clk);
        chk("bp_release_ready", 32'(r0), 32'h1);
        step();
        drive(1'b0, 8'h00, 2'd0, 1'b0);
        @(negedge clk);
        chk("bp_second_valid", 32'(v0), 32'h8);
        chk("bp_second_data", 32'(d0), 32'h22);
        out_ready = 4'b1111;
        step();

        for (int i = 0; i < 3; i++) begin
            logic [1:0] sels [3];
            sels = '{2'd0, 2'd3, 2'd1};
            drive(1'b1, 8'(i + 1), sels[i], i == 2);
            step();
            @(negedge clk);
            chk("lock_valid", 32'(v1), 32'h1);
            chk("lock_data", 32'(d1), 32'(i + 1));
        end
        chk("lock_cnt", 32'(c1), 32'h4);
        drive(1'b1, 8'h44, 2'd2, 1'b1);
        step();
        drive(1'b0, 8'h00, 2'd0, 1'b0);
        @(negedge clk);
        chk("lock_idle_valid", 32'(v1), 32'h4);
        chk("lock_idle_cnt", 32'(c1), 32'h5);
        step();

        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 8'(8'h80 + i), (i % 2 == 0) ? 2'd0 : 2'd3, 1'b1);
            @(negedge clk);
            chk("thr_in_ready", 32'(r0), 32'h1);
            step();
            @(negedge clk);
            chk("thr_valid", 32'(v0), (i % 2 == 0) ? 32'h1 : 32'h8);
            chk("thr_data", 32'(d0), 32'(8'h80 + i));
        end
        drive(1'b0, 8'h00, 2'd0, 1'b0);

        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, 8'(i), 2'(i), 1'b1);
            step();
            if (i == 254) begin
                @(negedge clk);
                chk("wrap_cnt_255", 32'(c0), 32'hFF);
            end
        end
        drive(1'b0, 8'h00, 2'd0, 1'b0);
        @(negedge clk);
        chk("wrap_cnt_0", 32'(c0), 32'h0);
        step();

        drive(1'b1, 8'h61, 2'd1, 1'b0);
        step();
        drive(1'b1, 8'h62, 2'd2, 1'b0);
        step();
        @(negedge clk);
        chk("lock_hold_dest", 32'(v1), 32'h2);
        rst = 1'b1;
        drive(1'b1, 8'h63, 2'd1, 1'b0);
        step();
        rst = 1'b0;
        drive(1'b1, 8'h64, 2'd3, 1'b0);
        step();
        drive(1'b0, 8'h00, 2'd0, 1'b0);
        @(negedge clk);
        chk("rst_unlock_valid", 32'(v1), 32'h8);
        chk("rst_unlock_data", 32'(d1), 32'h64);
        step();

        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 99) == 0);
            out_ready = 4'($urandom);
            drive($urandom_range(0, 3) != 0, 8'($urandom), 2'($urandom),
                  $urandom_range(0, 2) == 0);
            step();
        end
        rst = 1'b0;
        drive(1'b0, 8'h00, 2'd0, 1'b0);
        step();
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
